// File: rtl/set_bank.sv
// set_bank: slow-mode settings bank. Holds NFLAG slow-enable flags and a TW-bit
// slow timeout written by address-encoded bus writes. Writes are qualified on
// the rising edge of a registered strobe. An unlock handshake guards them. A
// hold countdown keeps SlowActive high after each slow-qualifying access.
//
// Unlock FSM states:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_LOCKED | settings writes are refused and pulse WrReject
//   ST_ARMED  | one settings write may be accepted; arm counter runs down
module set_bank #(
    parameter int              NFLAG     = 7,
    parameter int              TW        = 4,
    parameter logic [NFLAG-1:0] RST_FLAGS = {NFLAG{1'b1}},
    parameter int              LOCK_EN   = 1,
    parameter int              ARM_CYC   = 255
) (
    input  logic                CLK,
    input  logic                nPOR,
    input  logic                BACT,
    input  logic                SetCSWR,
    input  logic                UnlkCSWR,
    input  logic [TW+NFLAG:1]   A,
    input  logic                SlowEvent,
    input  logic                Tick,
    output logic [NFLAG-1:0]    SlowFlags,
    output logic [TW-1:0]       SlowTimeout,
    output logic                SlowActive,
    output logic                Armed,
    output logic                WrReject
);

    typedef enum logic {
        ST_LOCKED = 1'b0,
        ST_ARMED  = 1'b1
    } lock_state_t;

    localparam logic [15:0] ARM_LOAD = 16'(ARM_CYC);
    // Without locking the bank sits permanently armed.
    localparam lock_state_t ST_RESET = (LOCK_EN != 0) ? ST_ARMED : ST_LOCKED;
    localparam lock_state_t ST_INIT  = (LOCK_EN != 0) ? ST_LOCKED : ST_ARMED;

    logic                sw_q, sw_d, sw_dly_q, sw_dly_d;
    logic                uw_q, uw_d, uw_dly_q, uw_dly_d;
    logic [TW+NFLAG:1]   a_q, a_d;
    logic [NFLAG-1:0]    flags_q, flags_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [TW-1:0]       hold_q, hold_d;
    logic                act_q, act_d;
    logic                rej_q, rej_d;
    lock_state_t         state_q, state_d;
    logic [15:0]         arm_cnt_q, arm_cnt_d;

    logic                set_ev;
    logic                unl_ev;
    logic                accept;

    // Strobe registration and address capture; events are strobe rising edges.
    always_comb begin
        sw_d     = BACT && SetCSWR;
        uw_d     = BACT && UnlkCSWR;
        sw_dly_d = sw_q;
        uw_dly_d = uw_q;
        a_d      = A;
        set_ev   = sw_q && !sw_dly_q;
        unl_ev   = uw_q && !uw_dly_q;
    end

    // Unlock FSM: a settings event is judged against the pre-edge state.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        accept    = 1'b0;
        rej_d     = 1'b0;
        if (LOCK_EN == 0) begin
            state_d   = ST_ARMED;
            arm_cnt_d = '0;
            accept    = set_ev;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    rej_d = set_ev;
                    if (unl_ev) begin
                        state_d   = ST_ARMED;
                        arm_cnt_d = ARM_LOAD;
                    end
                end
                ST_ARMED: begin
                    accept = set_ev;
                    if (unl_ev) begin
                        arm_cnt_d = ARM_LOAD;
                    end else if (set_ev) begin
                        state_d   = ST_LOCKED;
                        arm_cnt_d = '0;
                    end else begin
                        arm_cnt_d = arm_cnt_q - 16'd1;
                        if (arm_cnt_d == 16'd0) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                default: begin
                    state_d   = ST_LOCKED;
                    arm_cnt_d = '0;
                end
            endcase
        end
    end

    // Settings update from the address captured with the strobe.
    always_comb begin
        flags_d = flags_q;
        tmo_d   = tmo_q;
        if (accept) begin
            flags_d = a_q[NFLAG:1];
            tmo_d   = a_q[TW+NFLAG:NFLAG+1];
        end
    end

    // Hold countdown: a load beats a tick, and the count saturates at zero.
    // A load uses the timeout held before this edge.
    always_comb begin
        hold_d = hold_q;
        if (SlowEvent) begin
            hold_d = tmo_q;
        end else if (Tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end
        act_d = (hold_d != '0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            sw_q      <= 1'b0;
            sw_dly_q  <= 1'b0;
            uw_q      <= 1'b0;
            uw_dly_q  <= 1'b0;
            a_q       <= '0;
            flags_q   <= RST_FLAGS;
            tmo_q     <= '0;
            hold_q    <= '0;
            act_q     <= 1'b0;
            rej_q     <= 1'b0;
            state_q   <= ST_INIT;
            arm_cnt_q <= '0;
        end else begin
            sw_q      <= sw_d;
            sw_dly_q  <= sw_dly_d;
            uw_q      <= uw_d;
            uw_dly_q  <= uw_dly_d;
            a_q       <= a_d;
            flags_q   <= flags_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            act_q     <= act_d;
            rej_q     <= rej_d;
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign SlowFlags   = flags_q;
    assign SlowTimeout = tmo_q;
    assign SlowActive  = act_q;
    assign WrReject    = rej_q;
    assign Armed       = (state_q == ST_RESET) ? (LOCK_EN != 0) : (LOCK_EN == 0);

endmodule

// File: tb/tb_set_bank.sv
// Testbench for set_bank: a locked default build plus a LOCK_EN=0 build on the
// same stimulus. Bus addresses are given as full byte addresses; the bank sees
// address bits [11:1], so flags = addr[7:1] and timeout = addr[11:8].
module tb_set_bank;

    localparam int NFLAG = 7;
    localparam int TW    = 4;

    localparam int S_FLAGS  = 0;
    localparam int S_TMO    = 1;
    localparam int S_ACT    = 2;
    localparam int S_ARM    = 3;
    localparam int S_REJ    = 4;
    localparam int S_FLAGS0 = 5;
    localparam int S_TMO0   = 6;
    localparam int S_ARM0   = 7;
    localparam int S_REJ0   = 8;
    localparam int S_MEAS   = 9;

    logic              clk = 1'b0;
    logic              npor;
    logic              bact, set_cs, unl_cs, se, tick;
    logic [TW+NFLAG:1] a;

    logic [NFLAG-1:0]  flags, flags0;
    logic [TW-1:0]     tmo, tmo0;
    logic              act, act0, arm, arm0, rej, rej0;

    int                vectors = 0;
    int                miscompares = 0;
    int                meas;
    logic              seen_rej = 1'b0;
    logic              seen_rej0 = 1'b0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    set_bank #(.NFLAG(NFLAG), .TW(TW), .LOCK_EN(1), .ARM_CYC(255)) u_dut (
        .CLK(clk), .nPOR(npor), .BACT(bact), .SetCSWR(set_cs), .UnlkCSWR(unl_cs),
        .A(a), .SlowEvent(se), .Tick(tick),
        .SlowFlags(flags), .SlowTimeout(tmo), .SlowActive(act),
        .Armed(arm), .WrReject(rej)
    );

    set_bank #(.NFLAG(NFLAG), .TW(TW), .LOCK_EN(0), .ARM_CYC(255)) u_dut0 (
        .CLK(clk), .nPOR(npor), .BACT(bact), .SetCSWR(set_cs), .UnlkCSWR(unl_cs),
        .A(a), .SlowEvent(se), .Tick(tick),
        .SlowFlags(flags0), .SlowTimeout(tmo0), .SlowActive(act0),
        .Armed(arm0), .WrReject(rej0)
    );

    always @(negedge clk) begin
        if (rej === 1'b1)  seen_rej = 1'b1;
        if (rej0 === 1'b1) seen_rej0 = 1'b1;
    end

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_FLAGS:  return 32'(flags);
            S_TMO:    return 32'(tmo);
            S_ACT:    return 32'(act);
            S_ARM:    return 32'(arm);
            S_REJ:    return 32'(rej);
            S_FLAGS0: return 32'(flags0);
            S_TMO0:   return 32'(tmo0);
            S_ARM0:   return 32'(arm0);
            S_REJ0:   return 32'(rej0);
            default:  return 32'(meas);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            vectors++;
            assert (o === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic bus_set(input logic [11:0] addr, input int hold);
        a      = addr[11:1];
        bact   = 1'b1;
        set_cs = 1'b1;
        repeat (hold) @(negedge clk);
        bact   = 1'b0;
        set_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_unl();
        bact   = 1'b1;
        unl_cs = 1'b1;
        @(negedge clk);
        bact   = 1'b0;
        unl_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_reset_values(input string tag);
        push({tag, "_flags"}, S_FLAGS, 32'h7F);
        push({tag, "_tmo"}, S_TMO, 32'h0);
        push({tag, "_act"}, S_ACT, 32'h0);
        push({tag, "_arm"}, S_ARM, 32'h0);
        push({tag, "_rej"}, S_REJ, 32'h0);
        push({tag, "_flags0"}, S_FLAGS0, 32'h7F);
        push({tag, "_tmo0"}, S_TMO0, 32'h0);
        push({tag, "_arm0"}, S_ARM0, 32'h1);
    endtask

    initial begin
        logic [11:0] addr;
        npor = 1'b0; bact = 1'b0; set_cs = 1'b0; unl_cs = 1'b0;
        se = 1'b0; tick = 1'b0; a = '0; meas = 0;
        repeat (2) @(negedge clk);
        npor = 1'b1;
        @(negedge clk);

        // Reset defaults
        push_reset_values("reset");
        check_sb();

        // Settings write while locked: one reject pulse, registers unchanged
        addr   = 12'h5A5;
        a      = addr[11:1];
        bact   = 1'b1;
        set_cs = 1'b1;
        @(negedge clk);
        push("lk_rej_pre", S_REJ, 32'h0);
        check_sb();
        @(negedge clk);
        push("lk_rej_pulse", S_REJ, 32'h1);
        push("lk_flags_d0", S_FLAGS0, 32'(addr[7:1]));
        push("lk_tmo_d0", S_TMO0, 32'(addr[11:8]));
        check_sb();
        @(negedge clk);
        push("lk_rej_end", S_REJ, 32'h0);
        bact   = 1'b0;
        set_cs = 1'b0;
        @(negedge clk);
        push("lk_flags", S_FLAGS, 32'h7F);
        push("lk_tmo", S_TMO, 32'h0);
        check_sb();

        // Unlock, then a long write: one update, relocks
        bus_unl();
        push("ul_armed", S_ARM, 32'h1);
        check_sb();
        seen_rej = 1'b0;
        addr = 12'h3C2;
        bus_set(addr, 6);
        push("wr_flags", S_FLAGS, 32'h61);
        push("wr_tmo", S_TMO, 32'h3);
        push("wr_arm", S_ARM, 32'h0);
        push("wr_no_rej", S_REJ, 32'h0);
        push("wr_flags_d0", S_FLAGS0, 32'h61);
        push("wr_tmo_d0", S_TMO0, 32'h3);
        meas = 32'(seen_rej);
        push("wr_single_event", S_MEAS, 32'h0);
        check_sb();

        // Arm window expires after 255 cycles; next write refused
        bact   = 1'b1;
        unl_cs = 1'b1;
        @(negedge clk);
        bact   = 1'b0;
        unl_cs = 1'b0;
        meas = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (arm === 1'b1) meas++;
            else if (meas > 0) break;
        end
        push("arm_window_len", S_MEAS, 32'd255);
        check_sb();
        seen_rej = 1'b0;
        bus_set(12'h0FE, 2);
        meas = 32'(seen_rej);
        push("exp_rejected", S_MEAS, 32'h1);
        push("exp_flags", S_FLAGS, 32'h61);
        push("exp_tmo", S_TMO, 32'h3);
        check_sb();

        // Hold countdown with timeout 3 and Tick every cycle
        se   = 1'b1;
        tick = 1'b0;
        meas = 0;
        @(negedge clk);
        if (act === 1'b1) meas++;
        se   = 1'b0;
        tick = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (act === 1'b1) meas++;
        end
        push("hold_len", S_MEAS, 32'd3);
        check_sb();

        // SlowEvent coincident with Tick mid-countdown reloads the count
        se   = 1'b1;
        tick = 1'b0;
        meas = 0;
        @(negedge clk);
        if (act === 1'b1) meas++;
        se   = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        if (act === 1'b1) meas++;
        se = 1'b1;
        @(negedge clk);
        if (act === 1'b1) meas++;
        se = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (act === 1'b1) meas++;
        end
        push("hold_reload_len", S_MEAS, 32'd5);
        push("hold_no_wrap", S_ACT, 32'h0);
        check_sb();
        tick = 1'b0;

        // Reset mid-countdown and mid-armed-window
        bus_unl();
        se = 1'b1;
        @(negedge clk);
        se = 1'b0;
        push("pre_rst_arm", S_ARM, 32'h1);
        push("pre_rst_act", S_ACT, 32'h1);
        check_sb();
        npor = 1'b0;
        @(negedge clk);
        push_reset_values("midrst");
        check_sb();
        npor = 1'b1;
        @(negedge clk);

        // The unlocked build never pulses WrReject
        meas = 32'(seen_rej0);
        push("nolock_never_rej", S_MEAS, 32'h0);
        check_sb();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
